// File: rtl/dds_sine_pkg.sv
// Shared constants and elaboration helpers for the DDS sine source.
// Quarter-wave ROM contents are computed here at elaboration time.
package dds_sine_pkg;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam real PI = 3.14159265358979323846;

  // round(amp * sin(pi * k / 2^(addr_w-1))), Taylor series on [0, pi/2]
  function automatic int rom_entry(int k, int addr_w, int amp);
    real x;
    real term;
    real sum;
    x = PI * real'(k) / real'(1 << (addr_w - 1));
    term = x;
    sum = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum = sum + term;
    end
    return $rtoi(real'(amp) * sum + 0.5);
  endfunction

  // Peak magnitude must fit in the signed half-range of the sample.
  function automatic bit amp_fits(int amp, int ow);
    return (amp >= 0) && (amp <= (1 << (ow - 1)) - 1);
  endfunction

endpackage

// File: rtl/dds_sine_gen_rom.sv
// Registered quarter-wave sine ROM, one or two read ports.
// Entry k holds round(AMPLITUDE*sin(pi*k/2^(ROM_ADDR_WIDTH-1))).
module sine_quarter_rom
  import dds_sine_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int OUTPUT_WIDTH   = 12,
  parameter int AMPLITUDE      = 1000,
  parameter int NUM_PORTS      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [ROM_ADDR_WIDTH-2:0] addr_a,
  input  logic [ROM_ADDR_WIDTH-2:0] addr_b,
  output logic [OUTPUT_WIDTH-1:0]   q_a,
  output logic [OUTPUT_WIDTH-1:0]   q_b
);

  localparam int DEPTH = (1 << (ROM_ADDR_WIDTH - 2)) + 1;

  logic [OUTPUT_WIDTH-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int V = rom_entry(k, ROM_ADDR_WIDTH, AMPLITUDE);
    assign rom[k] = OUTPUT_WIDTH'(V);
  end

  // Port A read register, held while the pipeline stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a <= '0;
    end else if (rd_en) begin
      q_a <= rom[addr_a];
    end
  end

  if (NUM_PORTS == 2) begin : g_port_b
    // Port B read register, same timing as port A
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_b <= '0;
      end else if (rd_en) begin
        q_b <= rom[addr_b];
      end
    end
  end else begin : g_no_port_b
    logic unused_b;
    assign unused_b = ^addr_b;
    assign q_b = '0;
  end

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine source: phase accumulator, folded quarter ROM, 3-stage pipe.
// Define COS_OUT_EN to add the quadrature cos_out port.
module dds_sine_gen
  import dds_sine_pkg::*;
#(
  parameter int OUTPUT_WIDTH   = 12,
  parameter int PHASE_WIDTH    = 32,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int AMPLITUDE      = 1000,
  parameter int MIDSCALE       = 2 ** (OUTPUT_WIDTH - 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [PHASE_WIDTH-1:0]  ftw_in,
  input  logic [PHASE_WIDTH-1:0]  pof_in,
  input  logic [1:0]              amp_shift,
  input  logic                    phase_clr,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    data_valid,
  input  logic                    data_ready
`ifdef COS_OUT_EN
  ,
  output logic [OUTPUT_WIDTH-1:0] cos_out
`endif
);

  localparam int RAW = ROM_ADDR_WIDTH;
  localparam int QW  = RAW - 2;
  localparam int IW  = RAW - 1;
  localparam logic [IW-1:0] QUARTER = IW'(1 << QW);
  localparam logic [OUTPUT_WIDTH-1:0] MID = OUTPUT_WIDTH'(MIDSCALE);

`ifdef COS_OUT_EN
  localparam int ROM_PORTS = 2;
`else
  localparam int ROM_PORTS = 1;
`endif

  if (!amp_fits(AMPLITUDE, OUTPUT_WIDTH)) begin : g_amp_check
    $error("AMPLITUDE does not fit OUTPUT_WIDTH");
  end

  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] ftw_r;
  logic [PHASE_WIDTH-1:0] pof_r;
  logic [1:0]             amp_r;

  logic                   advance;
  logic                   take;
  logic [PHASE_WIDTH-1:0] phase;
  logic [RAW-1:0]         addr;

  logic                   s1_valid;
  logic [RAW-1:0]         s1_addr;
  logic [IW-1:0]          idx_ext;
  logic [IW-1:0]          rom_idx;

  logic                   s2_valid;
  logic                   s2_neg;
  logic [OUTPUT_WIDTH-1:0] rom_q;
  logic [OUTPUT_WIDTH-1:0] rom_cq;
  logic [OUTPUT_WIDTH-1:0] mag;
  logic [IW-1:0]          cos_idx;

  assign advance = !data_valid || data_ready;
  assign take    = en && advance;
  assign phase   = acc + pof_r;
  assign addr    = phase[PHASE_WIDTH-1 -: RAW];
  assign idx_ext = {1'b0, s1_addr[QW-1:0]};

  logic unused_phase;
  assign unused_phase = ^phase[PHASE_WIDTH-RAW-1:0];

  // Config capture, independent of pipeline stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_r <= '0;
      pof_r <= '0;
      amp_r <= '0;
    end else if (cfg_load) begin
      ftw_r <= ftw_in;
      pof_r <= pof_in;
      amp_r <= amp_shift;
    end
  end

  // Phase accumulator; clear wins over the advance add
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (phase_clr) begin
      acc <= '0;
    end else if (take) begin
      acc <= acc + ftw_r;
    end
  end

  // S1: capture full-wave address of the entering sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else if (advance) begin
      s1_valid <= en;
      if (en) begin
        s1_addr <= addr;
      end
    end
  end

  // Fold the quadrant onto the quarter-wave table index
  always_comb begin
    rom_idx = idx_ext;
    unique case (s1_addr[RAW-1 -: 2])
      QUAD_0, QUAD_2: rom_idx = idx_ext;
      QUAD_1, QUAD_3: rom_idx = QUARTER - idx_ext;
    endcase
  end

`ifdef COS_OUT_EN
  logic [1:0] cquad;
  logic       s2_cneg;
  assign cquad = s1_addr[RAW-1 -: 2] + 2'd1;

  // Cosine fold: same index, quadrant advanced by one
  always_comb begin
    cos_idx = idx_ext;
    unique case (cquad)
      QUAD_0, QUAD_2: cos_idx = idx_ext;
      QUAD_1, QUAD_3: cos_idx = QUARTER - idx_ext;
    endcase
  end
`else
  assign cos_idx = '0;
`endif

  sine_quarter_rom #(
    .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH),
    .OUTPUT_WIDTH   (OUTPUT_WIDTH),
    .AMPLITUDE      (AMPLITUDE),
    .NUM_PORTS      (ROM_PORTS)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (advance),
    .addr_a (rom_idx),
    .addr_b (cos_idx),
    .q_a    (rom_q),
    .q_b    (rom_cq)
  );

  // S2: sign flags travel alongside the registered ROM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_neg   <= s1_addr[RAW-1];
    end
  end

  assign mag = rom_q >> amp_r;

  // S3: scale, apply sign around midscale, present to consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
      data_out   <= MID;
    end else if (advance) begin
      data_valid <= s2_valid;
      if (s2_valid) begin
        data_out <= s2_neg ? MID - mag : MID + mag;
      end
    end
  end

`ifdef COS_OUT_EN
  logic [OUTPUT_WIDTH-1:0] cmag;
  assign cmag = rom_cq >> amp_r;

  // Cosine sign flag, aligned with S2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_cneg <= 1'b0;
    end else if (advance) begin
      s2_cneg <= cquad[1];
    end
  end

  // Cosine output register, aligned with data_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_out <= MID;
    end else if (advance && s2_valid) begin
      cos_out <= s2_cneg ? MID - cmag : MID + cmag;
    end
  end
`else
  logic unused_cq;
  assign unused_cq = ^rom_cq;
`endif

endmodule

// File: tb/tb_dds_sine_gen.sv
// Self-checking bench for dds_sine_gen: vector table, directed
// handshake/clear/reset sequences and random configs vs a sine model.
module tb_dds_sine_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] ftw_in = '0;
  logic [31:0] pof_in = '0;
  logic [1:0]  amp_shift = '0;
  logic        phase_clr = 1'b0;
  logic [11:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
`ifdef COS_OUT_EN
  logic [11:0] cos_out;
`endif

  always #5 clk = ~clk;

  dds_sine_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_load   (cfg_load),
    .ftw_in     (ftw_in),
    .pof_in     (pof_in),
    .amp_shift  (amp_shift),
    .phase_clr  (phase_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready)
`ifdef COS_OUT_EN
    ,
    .cos_out    (cos_out)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int got[$];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ideal sine: midscale + round(1000*sin(2*pi*a/256)) >> shift
  function automatic int model(logic [31:0] f, logic [31:0] p,
                               int amp, int n);
    logic [31:0] ph;
    int a;
    real s;
    int mag;
    ph = f * 32'(n) + p;
    a = int'(ph[31:24]);
    s = $sin(2.0 * 3.141592653589793 * real'(a) / 256.0);
    if (s < 0.0) s = -s;
    mag = $rtoi(1000.0 * s + 0.5) >> amp;
    return (a >= 128) ? 2048 - mag : 2048 + mag;
  endfunction

  // Monitor: collect accepted samples, verify hold during stall
  logic        prev_stall = 1'b0;
  logic [11:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", int'(data_valid), 1);
        check("hold_data", int'(data_out), int'(prev_out));
      end
      if (data_valid && data_ready) got.push_back(int'(data_out));
      prev_stall = data_valid && !data_ready;
      prev_out = data_out;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    cfg_load = 1'b0;
    phase_clr = 1'b0;
    data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic configure(logic [31:0] f, logic [31:0] p, int a);
    ftw_in = f;
    pof_in = p;
    amp_shift = 2'(a);
    cfg_load = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask

  task automatic capture(int n, bit rnd_ready);
    int cyc;
    cyc = 0;
    got.delete();
    en = 1'b1;
    while (got.size() < n && cyc < n * 8 + 50) begin
      if (rnd_ready) data_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1 cyc++;
    end
    en = 1'b0;
    data_ready = 1'b1;
    if (got.size() < n) check("capture_timeout", got.size(), n);
  endtask

  typedef struct {
    logic [31:0] ftw;
    logic [31:0] pof;
    int          amp;
    int          idx;
    int          exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int lat;
    int cyc;
    logic [31:0] f;
    logic [31:0] p;
    int a;
    bit first;

    tbl.push_back('{32'h0100_0000, 0, 0, 0, 2048, "f24_s0"});
    tbl.push_back('{32'h0100_0000, 0, 0, 1, 2073, "f24_s1"});
    tbl.push_back('{32'h0100_0000, 0, 0, 2, 2097, "f24_s2"});
    tbl.push_back('{32'h0100_0000, 0, 0, 3, 2122, "f24_s3"});
    tbl.push_back('{32'h0100_0000, 0, 0, 64, 3048, "f24_s64"});
    tbl.push_back('{32'h0100_0000, 0, 0, 128, 2048, "f24_s128"});
    tbl.push_back('{32'h0100_0000, 0, 0, 192, 1048, "f24_s192"});
    tbl.push_back('{32'h0100_0000, 0, 0, 256, 2048, "f24_s256"});
    tbl.push_back('{32'h0100_0000, 0, 1, 64, 2548, "amp1_s64"});
    tbl.push_back('{32'h0100_0000, 0, 1, 192, 1548, "amp1_s192"});
    tbl.push_back('{32'h0, 32'h4000_0000, 0, 0, 3048, "pof_s0"});
    tbl.push_back('{32'h0, 32'h4000_0000, 0, 7, 3048, "pof_s7"});
    tbl.push_back('{32'h8000_0000, 0, 0, 0, 2048, "f31_s0"});
    tbl.push_back('{32'h8000_0000, 0, 0, 1, 2048, "f31_s1"});
    tbl.push_back('{32'h4000_0000, 0, 0, 0, 2048, "f30_s0"});
    tbl.push_back('{32'h4000_0000, 0, 0, 1, 3048, "f30_s1"});
    tbl.push_back('{32'h4000_0000, 0, 0, 2, 2048, "f30_s2"});
    tbl.push_back('{32'h4000_0000, 0, 0, 3, 1048, "f30_s3"});
    tbl.push_back('{32'h4000_0000, 0, 0, 5, 3048, "f30_s5"});

    // Reset state
    do_reset();
    check("rst_valid", int'(data_valid), 0);
    check("rst_data", int'(data_out), 2048);
`ifdef COS_OUT_EN
    check("rst_cos", int'(cos_out), 2048);
`endif

    // Latency from first accepted sample
    configure(32'h0100_0000, 0, 0);
    en = 1'b1;
    lat = 0;
    while (!data_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, 3);
    en = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Vector table
    first = 1'b1;
    f = '0;
    p = '0;
    a = 0;
    foreach (tbl[i]) begin
      if (first || tbl[i].ftw != f || tbl[i].pof != p ||
          tbl[i].amp != a) begin
        first = 1'b0;
        f = tbl[i].ftw;
        p = tbl[i].pof;
        a = tbl[i].amp;
        do_reset();
        configure(f, p, a);
        capture(260, 1'b0);
      end
      if (got.size() > tbl[i].idx)
        check(tbl[i].name, got[tbl[i].idx], tbl[i].exp);
    end

    // Backpressure: ready low for 5 cycles mid-stream
    do_reset();
    configure(32'h0100_0000, 0, 0);
    got.delete();
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1 data_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 data_ready = 1'b1;
    cyc = 0;
    while (got.size() < 60 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    en = 1'b0;
    check("bp_count", int'(got.size() >= 60), 1);
    for (int i = 0; i < 60 && i < got.size(); i++)
      check("bp_seq", got[i], model(32'h0100_0000, 0, 0, i));

    // phase_clr while streaming: clear-cycle sample uses old acc
    do_reset();
    configure(32'h0100_0000, 0, 0);
    got.delete();
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1 phase_clr = 1'b1;
    @(posedge clk);
    #1 phase_clr = 1'b0;
    repeat (20) @(posedge clk);
    #1 en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("clr_count", got.size(), 41);
    for (int i = 0; i < 41 && i < got.size(); i++)
      check("clr_seq", got[i],
            model(32'h0100_0000, 0, 0, (i <= 20) ? i : i - 21));

    // Asynchronous reset mid-stream, then restart from acc=0
    do_reset();
    configure(32'h0100_0000, 0, 0);
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_valid", int'(data_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(data_valid), 0);
    check("mid_rst_data", int'(data_out), 2048);
    @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b0;
    configure(32'h0100_0000, 0, 0);
    capture(4, 1'b0);
    if (got.size() >= 4) begin
      check("restart_s0", got[0], 2048);
      check("restart_s1", got[1], 2073);
      check("restart_s2", got[2], 2097);
      check("restart_s3", got[3], 2122);
    end

    // Random configs with random backpressure
    repeat (6) begin
      f = $urandom;
      p = $urandom;
      a = $urandom_range(0, 3);
      do_reset();
      configure(f, p, a);
      capture(64, 1'b1);
      for (int i = 0; i < 64 && i < got.size(); i++)
        check("rand_seq", got[i], model(f, p, a, i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
- Parametrised direct digital synthesis (DDS) sine source. It is the clocked successor to the combinational full-wave sine table.
- A phase accumulator with a programmable frequency tuning word (FTW) and phase offset drives a quarter-wave ROM with symmetry folding.
- Amplitude is scalable by right shift. Output is offset-binary for the DAC/transmit path, with a valid/ready handshake so downstream logic can apply backpressure.

Parameters:
- OUTPUT_WIDTH, 12, sample width (offset binary).
- PHASE_WIDTH, 32, accumulator/FTW/offset width.
- ROM_ADDR_WIDTH, 8, full-wave phase resolution (top bits of phase used); quarter ROM holds 2^(ROM_ADDR_WIDTH-2)+1 entries.
- AMPLITUDE, 1000, peak magnitude; must be ≤ 2^(OUTPUT_WIDTH-1)-1, else elaboration error.
- MIDSCALE, 2048, zero-level code (default 2^(OUTPUT_WIDTH-1)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  allows new samples to enter the pipeline.
- cfg_load  in  1  one-cycle strobe that captures ftw_in, pof_in, amp_shift.
- ftw_in  in  PHASE_WIDTH  frequency tuning word.
- pof_in  in  PHASE_WIDTH  phase offset.
- amp_shift  in  2  magnitude right-shift (0..3).
- phase_clr  in  1  synchronous accumulator clear.
- data_out  out  OUTPUT_WIDTH  sample.
- data_valid  out  1  sample available.
- data_ready  in  1  downstream accept.
- cos_out  out  OUTPUT_WIDTH  cosine sample (COS_OUT_EN only).

Behaviour:
- Reset: acc=0, ftw_r=0, pof_r=0, amp_r=0; all stage valids=0; data_valid=0; data_out=MIDSCALE; cos_out=MIDSCALE.
- Config: on cfg_load, ftw_r/pof_r/amp_r update next edge regardless of stall. The new FTW applies from the next accumulator advance.
- Pipeline has 3 registered stages. Global advance = !data_valid || data_ready; when advance is 0 every stage holds.
  - S1: the sample enters when en && advance. phase = acc + pof_r (mod 2^PHASE_WIDTH), then acc <= acc + ftw_r. Addr a = phase[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH]; quadrant q = a[MSB:MSB-1]; idx = low ROM_ADDR_WIDTH-2 bits.
  - S2: fold and registered ROM read. Index = idx when q is 0 or 2; 2^(ROM_ADDR_WIDTH-2)-idx when q is 1 or 3. Negate flag = q[1].
  - S3: mag = Q >> amp_r. data_out = MIDSCALE+mag if not negated, else MIDSCALE-mag.
- Latency: 3 cycles from acceptance into S1 to data_valid (no stall). Sustained throughput is 1 sample/cycle when data_ready stays high.
- ROM contents: Q[k] = round(AMPLITUDE·sin(π·k/2^(ROM_ADDR_WIDTH-1))) for k = 0..2^(ROM_ADDR_WIDTH-2). Contents are computed at elaboration.
- Handshake: once data_valid is high, data_out holds stable until data_valid && data_ready. data_valid never drops without acceptance.
- en low: no new entries; in-flight samples drain; data_valid falls after the last one is accepted.
- phase_clr: acc <= 0 next edge; it has priority over the advance add. Samples in flight are still delivered. With advance and en both high in the same cycle, the entering sample uses the pre-clear acc.
- Wrap-around: acc and phase are modulo 2^PHASE_WIDTH with no saturation. An FTW of 0 gives a constant sample.
- Reset mid-operation: immediate return to reset values; in-flight samples are discarded.

Optional Feature:
- COS_OUT_EN defined:
  - cos_out is produced from the same phase + 2^(PHASE_WIDTH-2), i.e. quadrant +1.
  - Uses a second ROM read port.
  - Same latency and handshake, aligned with data_out.
- COS_OUT_EN undefined: cos_out port is absent and no second ROM port is built.

Decomposition:
- Package dds_sine_pkg holds:
  - quadrant encoding constants;
  - the constant function computing ROM entries;
  - the width-check helper for AMPLITUDE/OUTPUT_WIDTH.
- Sub-module sine_quarter_rom: registered quarter-wave ROM with 1 or 2 read ports (parameter), parametrised on ROM_ADDR_WIDTH/OUTPUT_WIDTH/AMPLITUDE.

Test Plan:
- Reset, then cfg_load ftw=2^24, pof=0, amp=0, en=1, ready=1 → first valid 3 cycles later, values 2048, 2073, 2097, 2122, …; sample 64=3048, 128=2048, 192=1048, 256=2048 (period 256).
- Same as the first scenario with amp_shift=1 → sample 64=2548, sample 192=1548.
- Backpressure: data_ready low for 5 cycles mid-stream → data_out held constant, no sample lost or duplicated; the sequence resumes exactly.
- pof=2^30 with ftw=0 → constant 3048. Then phase_clr with ftw=2^24 and pof=0 → the post-clear sample sequence restarts at 2048 after the in-flight samples are delivered.
- Wrap: ftw=2^31 → alternating 2048, 2048 (q0 idx0, q2 idx0). ftw=2^30 → 2048, 3048, 2048, 1048 repeating.
- Assert rst mid-stream with data_valid=1 → data_valid=0 and data_out=2048 immediately; restart from acc=0. With COS_OUT_EN, cos_out reads 3048 when data_out reads 2048 at phase 0.
